// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the divider HI/LO sequencer
package div_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;
    localparam int          CW          = 4;
endpackage

// File: rtl/reg32.sv
// reg32: 32-bit register with load enable and asynchronous active-low clear
//   clk  - rising-edge clock
//   clr  - async clear, active low
//   en   - load d on the next edge
//   d/q  - data in / registered data out
module reg32 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences the combinational divider and owns HI/LO/dz
//   clk, clr            - clock, async active-low reset
//   start, a_in, b_in   - divide request and operands
//   div_a, div_b        - registered operands to the divider
//   div_c               - divider result {ignored, remainder, quotient}
//   busy, done, dz      - SETTLE state, one-cycle completion pulse, sticky div-by-zero
//   dz_clr              - clears dz (a same-edge set wins)
//   bus_in, hi_ld/lo_ld - direct HI/LO loads, honoured outside SETTLE
//   hi_rd/lo_rd,bus_out - read port, HI has priority
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [64:0] div_c,
    output logic        busy,
    output logic        done,
    output logic        dz,
    input  logic        dz_clr,
    input  logic [31:0] bus_in,
    input  logic        hi_ld,
    input  logic        lo_ld,
    input  logic        hi_rd,
    input  logic        lo_rd,
    output logic [31:0] bus_out
);
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            dz_n;
    logic            accept, go, zero, cap, hi_en, lo_en;
    logic [31:0]     hi, lo, hi_d, lo_d;
    logic            unused_c;

    assign unused_c = div_c[64];

    // A start is only taken outside SETTLE; a zero divisor skips the divider entirely.
    assign accept = start && state != SETTLE;
    assign go     = accept && b_in != '0;
    assign zero   = accept && b_in == '0;
    assign cap    = state == SETTLE && cnt == '0;

    // Captures take precedence over bus loads; loads are blocked while settling.
    assign hi_en = cap || zero || (hi_ld && state != SETTLE);
    assign lo_en = cap || zero || (lo_ld && state != SETTLE);
    assign hi_d  = cap ? div_c[63:32] : zero ? a_in : bus_in;
    assign lo_d  = cap ? div_c[31:0] : zero ? DZ_QUOTIENT : bus_in;

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dz    <= dz_n;
        end

    always_comb begin
        state_n = state == SETTLE ? (cap ? DONE : SETTLE) : go ? SETTLE : zero ? DONE : IDLE;
        cnt_n   = go ? CW'(SETTLE_CYCLES - 1) : (state == SETTLE && cnt != '0) ? cnt - 1'b1 : cnt;
        dz_n    = zero ? 1'b1 : dz_clr ? 1'b0 : dz;
    end

    assign busy    = state == SETTLE;
    assign done    = state == DONE;
    assign bus_out = hi_rd ? hi : lo_rd ? lo : '0;

    reg32 u_hi (.clk(clk), .clr(clr), .en(hi_en), .d(hi_d), .q(hi));
    reg32 u_lo (.clk(clk), .clr(clr), .en(lo_en), .d(lo_d), .q(lo));
    reg32 u_a  (.clk(clk), .clr(clr), .en(go),    .d(a_in), .q(div_a));
    reg32 u_b  (.clk(clk), .clr(clr), .en(go),    .d(b_in), .q(div_b));
endmodule
